// File: rtl/rotary_counter_bank_if.sv
// Bundles the encoder inputs, per-channel clears and decoded outputs of a rotary_counter_bank.
// The master drives the A/B/clear inputs. The slave (the counter bank) drives position/step/left/error.
interface rotary_counter_bank_if #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 8
);
  logic [CHANNELS-1:0]       rotary_a;
  logic [CHANNELS-1:0]       rotary_b;
  logic [CHANNELS-1:0]       clear;
  logic [CHANNELS*WIDTH-1:0] position;
  logic [CHANNELS-1:0]       step;
  logic [CHANNELS-1:0]       left;
  logic [CHANNELS-1:0]       error;

  modport master (
    output rotary_a, rotary_b, clear,
    input  position, step, left, error
  );

  modport slave (
    input  rotary_a, rotary_b, clear,
    output position, step, left, error
  );
endinterface

// File: rtl/rotary_counter_bank.sv
// Multi-channel quadrature decoder with per-channel detent accumulator and wrap/saturate position counter.
// All outputs are registered. Channels are independent and share only clk/rst.
module rotary_counter_bank #(
  parameter int CHANNELS          = 2,
  parameter int WIDTH             = 8,
  parameter int STEP              = 1,
  parameter int COUNTS_PER_DETENT = 4,
  parameter int SATURATE          = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  rotary_counter_bank_if.slave  bus
);

  localparam logic [WIDTH:0]     STEP_W = (WIDTH+1)'(STEP);
  localparam logic signed [3:0]  CPD_S  = 4'(COUNTS_PER_DETENT);

  // Position of an {a,b} code along the right-turning Gray cycle 00->10->11->01.
  function automatic logic [1:0] gray_idx(input logic [1:0] ab);
    logic [1:0] idx;
    case (ab)
      2'b00:   idx = 2'd0;
      2'b10:   idx = 2'd1;
      2'b11:   idx = 2'd2;
      2'b01:   idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  logic [1:0]        prev_r    [CHANNELS];
  logic [WIDTH-1:0]  pos_r     [CHANNELS];
  logic signed [3:0] sub_r     [CHANNELS];
  logic [CHANNELS-1:0] step_r, left_r, err_r;

  logic [1:0]        delta_s   [CHANNELS];
  logic [WIDTH:0]    pos_up_s  [CHANNELS];
  logic [WIDTH:0]    pos_dn_s  [CHANNELS];
  logic signed [3:0] sub_inc_s [CHANNELS];
  logic signed [3:0] sub_dec_s [CHANNELS];

  logic [WIDTH-1:0]  pos_nxt_s [CHANNELS];
  logic signed [3:0] sub_nxt_s [CHANNELS];
  logic [CHANNELS-1:0] step_nxt_s, left_nxt_s, err_nxt_s;

  // Edge classification and candidate arithmetic; delta 1 = right, 3 = left, 2 = illegal.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      delta_s[i]   = gray_idx({bus.rotary_a[i], bus.rotary_b[i]}) - gray_idx(prev_r[i]);
      pos_up_s[i]  = {1'b0, pos_r[i]} + STEP_W;
      pos_dn_s[i]  = {1'b0, pos_r[i]} - STEP_W;
      sub_inc_s[i] = sub_r[i] + 4'sd1;
      sub_dec_s[i] = sub_r[i] - 4'sd1;
    end
  end

  // Next-state for accumulator, position and flags; clear overrides any edge.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      pos_nxt_s[i]  = pos_r[i];
      sub_nxt_s[i]  = sub_r[i];
      step_nxt_s[i] = 1'b0;
      left_nxt_s[i] = left_r[i];
      err_nxt_s[i]  = err_r[i];
      if (bus.clear[i]) begin
        pos_nxt_s[i] = {WIDTH{1'b0}};
        sub_nxt_s[i] = 4'sd0;
        err_nxt_s[i] = 1'b0;
      end else begin
        case (delta_s[i])
          2'd1: begin
            if (sub_inc_s[i] == CPD_S) begin
              sub_nxt_s[i]  = 4'sd0;
              step_nxt_s[i] = 1'b1;
              left_nxt_s[i] = 1'b0;
              // A carry out of WIDTH bits means the increment overflowed.
              if ((SATURATE != 0) && pos_up_s[i][WIDTH]) begin
                pos_nxt_s[i] = {WIDTH{1'b1}};
              end else begin
                pos_nxt_s[i] = pos_up_s[i][WIDTH-1:0];
              end
            end else begin
              sub_nxt_s[i] = sub_inc_s[i];
            end
          end
          2'd3: begin
            if (sub_dec_s[i] == -CPD_S) begin
              sub_nxt_s[i]  = 4'sd0;
              step_nxt_s[i] = 1'b1;
              left_nxt_s[i] = 1'b1;
              if ((SATURATE != 0) && pos_dn_s[i][WIDTH]) begin
                pos_nxt_s[i] = {WIDTH{1'b0}};
              end else begin
                pos_nxt_s[i] = pos_dn_s[i][WIDTH-1:0];
              end
            end else begin
              sub_nxt_s[i] = sub_dec_s[i];
            end
          end
          2'd2: begin
            err_nxt_s[i] = 1'b1;
          end
          default: begin
            sub_nxt_s[i] = sub_r[i];
          end
        endcase
      end
    end
  end

  // State registers; prev_ab follows the inputs even in reset so release never steps.
  always_ff @(posedge clk) begin
    for (int i = 0; i < CHANNELS; i++) begin
      prev_r[i] <= {bus.rotary_a[i], bus.rotary_b[i]};
      if (rst) begin
        pos_r[i]  <= {WIDTH{1'b0}};
        sub_r[i]  <= 4'sd0;
        step_r[i] <= 1'b0;
        left_r[i] <= 1'b0;
        err_r[i]  <= 1'b0;
      end else begin
        pos_r[i]  <= pos_nxt_s[i];
        sub_r[i]  <= sub_nxt_s[i];
        step_r[i] <= step_nxt_s[i];
        left_r[i] <= left_nxt_s[i];
        err_r[i]  <= err_nxt_s[i];
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_pos
    assign bus.position[g*WIDTH +: WIDTH] = pos_r[g];
  end

  assign bus.step  = step_r;
  assign bus.left  = left_r;
  assign bus.error = err_r;

endmodule

// File: tb/tb_rotary_counter_bank.sv
// Drives two counter-bank builds (CPD=4/STEP=1/wrap and CPD=1/STEP=3/saturate) with the same
// encoder stimulus and checks every output each cycle against a behavioural model.
module tb_rotary_counter_bank;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] ra  = 2'b11;
  logic [1:0] rb  = 2'b11;
  logic [1:0] clr = 2'b00;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rotary_counter_bank_if #(.CHANNELS(2), .WIDTH(8)) if_a ();
  rotary_counter_bank_if #(.CHANNELS(2), .WIDTH(8)) if_b ();

  assign if_a.rotary_a = ra;
  assign if_a.rotary_b = rb;
  assign if_a.clear    = clr;
  assign if_b.rotary_a = ra;
  assign if_b.rotary_b = rb;
  assign if_b.clear    = clr;

  rotary_counter_bank #(.CHANNELS(2), .WIDTH(8), .STEP(1), .COUNTS_PER_DETENT(4), .SATURATE(0))
    dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
  rotary_counter_bank #(.CHANNELS(2), .WIDTH(8), .STEP(3), .COUNTS_PER_DETENT(1), .SATURATE(1))
    dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));

  // Model configuration per build, and the Gray-cycle position of each {a,b} code.
  int cpd [2] = '{4, 1};
  int stp [2] = '{1, 3};
  int sat [2] = '{0, 1};
  int gidx[4] = '{0, 3, 1, 2};
  logic [1:0] ab_of[4] = '{2'b00, 2'b10, 2'b11, 2'b01};

  int m_pos [2][2];
  int m_sub [2][2];
  int m_step[2][2];
  int m_left[2][2];
  int m_err [2][2];
  int m_prev[2][2];

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_update();
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 2; c++) begin
        int cur;
        int dl;
        cur = int'({ra[c], rb[c]});
        if (rst) begin
          m_pos[d][c] = 0; m_sub[d][c] = 0; m_step[d][c] = 0;
          m_left[d][c] = 0; m_err[d][c] = 0;
        end else begin
          m_step[d][c] = 0;
          if (clr[c]) begin
            m_pos[d][c] = 0; m_sub[d][c] = 0; m_err[d][c] = 0;
          end else begin
            dl = (gidx[cur] - gidx[m_prev[d][c]] + 4) % 4;
            if (dl == 1) begin
              m_sub[d][c]++;
              if (m_sub[d][c] == cpd[d]) begin
                m_sub[d][c] = 0; m_step[d][c] = 1; m_left[d][c] = 0;
                if (sat[d] != 0) m_pos[d][c] = (m_pos[d][c] + stp[d] > 255) ? 255 : m_pos[d][c] + stp[d];
                else             m_pos[d][c] = (m_pos[d][c] + stp[d]) % 256;
              end
            end else if (dl == 3) begin
              m_sub[d][c]--;
              if (m_sub[d][c] == -cpd[d]) begin
                m_sub[d][c] = 0; m_step[d][c] = 1; m_left[d][c] = 1;
                if (sat[d] != 0) m_pos[d][c] = (m_pos[d][c] - stp[d] < 0) ? 0 : m_pos[d][c] - stp[d];
                else             m_pos[d][c] = (m_pos[d][c] - stp[d] + 256) % 256;
              end
            end else if (dl == 2) begin
              m_err[d][c] = 1;
            end
          end
        end
        m_prev[d][c] = cur;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 2; c++) begin
        string nm;
        nm = $sformatf("%s.%s%0d", tag, (d == 0) ? "A" : "B", c);
        check({nm, ".pos"},  int'((d == 0) ? if_a.position[c*8 +: 8] : if_b.position[c*8 +: 8]), m_pos[d][c]);
        check({nm, ".step"}, int'((d == 0) ? if_a.step[c]  : if_b.step[c]),  m_step[d][c]);
        check({nm, ".left"}, int'((d == 0) ? if_a.left[c]  : if_b.left[c]),  m_left[d][c]);
        check({nm, ".err"},  int'((d == 0) ? if_a.error[c] : if_b.error[c]), m_err[d][c]);
      end
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_update();
    #1;
    compare_all(tag);
  endtask

  task automatic set_ab(input int c, input logic [1:0] ab);
    ra[c] = ab[1];
    rb[c] = ab[0];
  endtask

  initial begin
    int g[2];
    int r;

    // Reset with A/B=11, then hold the inputs after release.
    repeat (3) tick("rst");
    rst = 1'b0;
    repeat (100) tick("idle");
    check("idle.A0.pos.const", int'(if_a.position[7:0]), 0);

    // Bring channel 0 to 00, clear its partial detent, then one full right detent.
    set_ab(0, 2'b01); tick("pre");
    set_ab(0, 2'b00); tick("pre");
    clr = 2'b01; tick("preclr");
    clr = 2'b00;
    set_ab(0, 2'b10); tick("right");
    set_ab(0, 2'b11); tick("right");
    set_ab(0, 2'b01); tick("right");
    set_ab(0, 2'b00); tick("right");
    check("right.A0.step.const", int'(if_a.step[0]), 1);
    check("right.A0.pos.const",  int'(if_a.position[7:0]), 1);
    tick("right.hold");

    // Left detent from position 0: wraps on build A, clamps on build B.
    clr = 2'b01; tick("clr0");
    clr = 2'b00;
    set_ab(0, 2'b01); tick("left");
    set_ab(0, 2'b11); tick("left");
    set_ab(0, 2'b10); tick("left");
    set_ab(0, 2'b00); tick("left");
    check("left.A0.pos.const",  int'(if_a.position[7:0]), 255);
    check("left.B0.pos.const",  int'(if_b.position[7:0]), 0);
    check("left.A0.left.const", int'(if_a.left[0]), 1);

    // Illegal jump on channel 1 is sticky until cleared.
    set_ab(1, 2'b00); tick("illegal");
    repeat (5) tick("sticky");
    check("sticky.A1.err.const", int'(if_a.error[1]), 1);
    clr = 2'b10; tick("clr1");
    clr = 2'b00;
    tick("clr1.after");
    check("clr1.A1.err.const", int'(if_a.error[1]), 0);

    // Clear wins over a completing edge; a half detent that reverses gives no step.
    set_ab(0, 2'b10); tick("pri");
    set_ab(0, 2'b11); tick("pri");
    set_ab(0, 2'b01); tick("pri");
    set_ab(0, 2'b00); clr = 2'b01; tick("pri.clr");
    clr = 2'b00;
    check("pri.A0.step.const", int'(if_a.step[0]), 0);
    set_ab(0, 2'b10); tick("half");
    set_ab(0, 2'b11); tick("half");
    set_ab(0, 2'b10); tick("half");
    set_ab(0, 2'b00); tick("half");

    // Both channels rotating together.
    g[0] = 0; g[1] = 0;
    for (int k = 0; k < 8; k++) begin
      g[0] = (g[0] + 1) % 4; g[1] = (g[1] + 1) % 4;
      set_ab(0, ab_of[g[0]]); set_ab(1, ab_of[g[1]]);
      tick("both");
    end
    check("both.B1.pos.const", int'(if_b.position[15:8]), 24);

    // Randomised walk: forward, backward, hold, occasional illegal jump and clear.
    for (int k = 0; k < 600; k++) begin
      for (int c = 0; c < 2; c++) begin
        r = int'($urandom_range(0, 19));
        if (r < 8)       g[c] = (g[c] + 1) % 4;
        else if (r < 15) g[c] = (g[c] + 3) % 4;
        else if (r == 15) g[c] = (g[c] + 2) % 4;
        set_ab(c, ab_of[g[c]]);
        clr[c] = ($urandom_range(0, 31) == 0) ? 1'b1 : 1'b0;
      end
      tick("rand");
    end
    clr = 2'b00;
    tick("end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
